// File: rtl/accel_pkg.sv
// Shared accelerator definitions: pair-buffer geometry and the feeder state encoding.
package accel_pkg;

    localparam int NPAIR      = 64;
    localparam int W          = 16;
    localparam int TILE_CNT_W = 8;
    localparam int IDX_W      = $clog2(NPAIR);

    typedef enum logic [2:0] {
        CLR,
        FILL,
        ISSUE,
        CAPTURE,
        OUT
    } feeder_state_t;

endpackage

// File: rtl/mac_feeder.sv
// Gathers activation/weight pairs into 64-slot tiles, presents each tile to the mac for one
// cycle, and returns the mac result together with the number of tiles issued for the neuron.
module mac_feeder
    import accel_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic [W-1:0]          in_weight,
    input  logic                  in_last,
    output logic                  mac_clr,
    output logic [NPAIR*W-1:0]    data_bus,
    output logic [NPAIR*W-1:0]    weight_bus,
    input  logic [W-1:0]          mac_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_result,
    output logic [TILE_CNT_W-1:0] out_tiles
);

    feeder_state_t         state;
    feeder_state_t         next_state;
    logic [IDX_W-1:0]      idx;
    logic [TILE_CNT_W-1:0] tile_cnt;
    logic                  tile_ended_last;
    logic                  accept;
    logic                  tile_full;

    logic [W-1:0] data_buf   [NPAIR];
    logic [W-1:0] weight_buf [NPAIR];

    // Handshake decodes; reset is folded in so nothing leaks out while reset is held.
    always_comb begin
        in_ready  = (state == FILL) && !reset;
        out_valid = (state == OUT) && !reset;
        mac_clr   = (state == CLR) || reset;
        accept    = in_valid && in_ready;
        tile_full = (idx == IDX_W'(NPAIR - 1));
    end

    always_comb begin
        next_state = state;
        case (state)
            CLR:     next_state = FILL;
            FILL:    if (accept && (in_last || tile_full)) next_state = ISSUE;
            ISSUE:   next_state = tile_ended_last ? CAPTURE : FILL;
            CAPTURE: next_state = OUT;
            OUT:     if (out_ready) next_state = CLR;
            default: next_state = CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= CLR;
            idx             <= '0;
            tile_cnt        <= '0;
            tile_ended_last <= 1'b0;
            out_result      <= '0;
            out_tiles       <= '0;
        end else begin
            state <= next_state;
            case (state)
                CLR: begin
                    idx             <= '0;
                    tile_cnt        <= '0;
                    tile_ended_last <= 1'b0;
                end
                FILL: begin
                    if (accept) begin
                        idx             <= idx + IDX_W'(1);
                        tile_ended_last <= in_last;
                    end
                end
                ISSUE: begin
                    idx <= '0;
                    if (tile_cnt != '1) tile_cnt <= tile_cnt + TILE_CNT_W'(1);
                end
                CAPTURE: begin
                    out_result <= mac_result;
                    out_tiles  <= tile_cnt;
                end
                default: ;
            endcase
        end
    end

    // Clearing the buffer on issue is what zero-pads the tail of a partial tile.
    always_ff @(posedge clk) begin
        if (reset || (state == ISSUE)) begin
            for (int k = 0; k < NPAIR; k++) begin
                data_buf[k]   <= '0;
                weight_buf[k] <= '0;
            end
        end else if (accept) begin
            data_buf[idx]   <= in_data;
            weight_buf[idx] <= in_weight;
        end
    end

    // The mac accumulates every cycle, so the buses must read zero outside ISSUE.
    always_comb begin
        data_bus   = '0;
        weight_bus = '0;
        if ((state == ISSUE) && !reset) begin
            for (int k = 0; k < NPAIR; k++) begin
                data_bus[k*W +: W]   = data_buf[k];
                weight_bus[k*W +: W] = weight_buf[k];
            end
        end
    end

endmodule
